nibble_fetch_seq: RTL and testbench

//  Fetch/sequencer front end for the 4-bit CPU; drives the microcode decoder from the other side.
//  - Generates phase; holds PC, IR (instr/operand) and C/Z flags.
//  - Consumes decoder strobes incPC/loadPC/loadFlags and program-ROM data.
//  - Sits between program ROM and decode; decode outputs feed back combinationally.

---
 rtl/nibble_pkg.sv | 52 +++++
 rtl/nibble_flag_reg.sv | 25 ++
 rtl/nibble_fetch_seq.sv | 149 ++++++++++++++
 tb/tb_nibble_fetch_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_pkg.sv
// Shared definitions for the 4-bit CPU front end and decoder.
// Opcodes, phase encoding, default widths and the decoder control bundle.
package nibble_pkg;

    localparam int DEF_PC_W  = 12;
    localparam int DEF_ROM_W = 8;
    localparam int DEF_RET_W = 16;

    localparam logic [3:0] OPC_JC   = 4'h0;
    localparam logic [3:0] OPC_JNC  = 4'h1;
    localparam logic [3:0] OPC_JZ   = 4'h2;
    localparam logic [3:0] OPC_JNZ  = 4'h3;
    localparam logic [3:0] OPC_LDI  = 4'h4;
    localparam logic [3:0] OPC_LDM  = 4'h5;
    localparam logic [3:0] OPC_STM  = 4'h6;
    localparam logic [3:0] OPC_ADDI = 4'h7;
    localparam logic [3:0] OPC_ADDM = 4'h8;
    localparam logic [3:0] OPC_SUBI = 4'h9;
    localparam logic [3:0] OPC_JMP  = 4'hA;
    localparam logic [3:0] OPC_AND  = 4'hB;
    localparam logic [3:0] OPC_OR   = 4'hC;
    localparam logic [3:0] OPC_IN   = 4'hD;
    localparam logic [3:0] OPC_OUT  = 4'hE;
    localparam logic [3:0] OPC_NOP  = 4'hF;

    typedef enum logic {
        PH_FETCH = 1'b0,
        PH_EXEC  = 1'b1
    } phase_e;

    typedef struct packed {
        logic       incPC;
        logic       loadPC;
        logic       loadA;
        logic       loadFlags;
        logic [2:0] S;
        logic       csRAM;
        logic       weRAM;
        logic       oeALU;
        logic       oeIN;
        logic       oeOperand;
        logic       loadOut;
    } ctrl_t;

    // Two-byte instructions carry the jump low byte in the next ROM word.
    function automatic logic is_two_byte(input logic [3:0] opc);
        return (opc == OPC_JC)  || (opc == OPC_JNC) ||
               (opc == OPC_JZ)  || (opc == OPC_JNZ) ||
               (opc == OPC_JMP);
    endfunction

endpackage

// File: rtl/nibble_flag_reg.sv
// Carry/zero flag register for the 4-bit CPU.
// Captures the ALU flags on the same edge the enable is high.
module nibble_flag_reg
(
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic carry_in,
    input  logic zero_in,
    output logic carry,
    output logic zero
);

    // Capture ALU flags when enabled, otherwise hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            carry <= 1'b0;
            zero  <= 1'b0;
        end else if (load) begin
            carry <= carry_in;
            zero  <= zero_in;
        end
    end

endmodule

// File: rtl/nibble_fetch_seq.sv
// Fetch/sequencer front end: phase, PC, IR, flags, retired counter.
// Optional freeze request when NIB_HALT_EN is defined.
module nibble_fetch_seq
    import nibble_pkg::*;
#(
    parameter int PC_W  = DEF_PC_W,
    parameter int ROM_W = DEF_ROM_W,
    parameter int RET_W = DEF_RET_W
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [ROM_W-1:0] rom_data,
    input  logic             incPC,
    input  logic             loadPC,
    input  logic             loadFlags,
    input  logic             alu_carry,
    input  logic             alu_zero,
`ifdef NIB_HALT_EN
    input  logic             halt,
`endif
    output logic [PC_W-1:0]  pc,
    output logic             phase,
    output logic [3:0]       instr,
    output logic [3:0]       operand,
    output logic             C,
    output logic             Z,
    output logic [RET_W-1:0] retired
);

    phase_e           phase_q;
    phase_e           phase_d;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_d;
    logic [3:0]       instr_q;
    logic [3:0]       instr_d;
    logic [3:0]       op_q;
    logic [3:0]       op_d;
    logic [RET_W-1:0] ret_q;
    logic [RET_W-1:0] ret_d;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  jump_tgt;
    logic             frozen;

    assign pc_inc   = pc_q + PC_W'(1);
    assign jump_tgt = PC_W'({op_q, rom_data});

`ifdef NIB_HALT_EN
    logic halted_q;
    logic halted_d;

    assign frozen = halted_q;

    // Halt flag: armed at an execute edge, released when halt drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    // Halt next-state: sampled only at execute edges or while halted.
    always_comb begin
        halted_d = halted_q;
        if (halted_q) begin
            halted_d = halt;
        end else if (phase_q == PH_EXEC) begin
            halted_d = halt;
        end
    end
`else
    assign frozen = 1'b0;
`endif

    // Phase state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= PH_FETCH;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Datapath registers: PC, IR and retired counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= '0;
            instr_q <= '0;
            op_q    <= '0;
            ret_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            op_q    <= op_d;
            ret_q   <= ret_d;
        end
    end

    // Next-state: fetch loads IR, execute resolves jump and retires.
    always_comb begin
        phase_d = phase_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        op_d    = op_q;
        ret_d   = ret_q;
        if (!frozen) begin
            unique case (phase_q)
                PH_FETCH: begin
                    instr_d = rom_data[ROM_W-1 -: 4];
                    op_d    = rom_data[3:0];
                    if (incPC) begin
                        pc_d = pc_inc;
                    end
                    phase_d = PH_EXEC;
                end
                PH_EXEC: begin
                    if (loadPC) begin
                        pc_d = jump_tgt;
                    end else if (incPC) begin
                        pc_d = pc_inc;
                    end
                    ret_d   = ret_q + RET_W'(1);
                    phase_d = PH_FETCH;
                end
                default: begin
                    phase_d = PH_FETCH;
                end
            endcase
        end
    end

    nibble_flag_reg u_flags (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (loadFlags & ~frozen),
        .carry_in (alu_carry),
        .zero_in  (alu_zero),
        .carry    (C),
        .zero     (Z)
    );

    assign pc      = pc_q;
    assign phase   = phase_q;
    assign instr   = instr_q;
    assign operand = op_q;
    assign retired = ret_q;

endmodule

// File: tb/tb_nibble_fetch_seq.sv
// Directed bench for nibble_fetch_seq with a combinational ROM array.
// Halt scenario is exercised only when NIB_HALT_EN is defined.
module tb_nibble_fetch_seq;

    logic        clk;
    logic        reset_n;
    logic [7:0]  rom_data;
    logic        incPC;
    logic        loadPC;
    logic        loadFlags;
    logic        alu_carry;
    logic        alu_zero;
    logic        halt;
    logic [11:0] pc;
    logic        phase;
    logic [3:0]  instr;
    logic [3:0]  operand;
    logic        C;
    logic        Z;
    logic [15:0] retired;

    logic [7:0] rom [0:4095];

    int checks = 0;
    int errors = 0;

    assign rom_data = rom[pc];

    nibble_fetch_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rom_data  (rom_data),
        .incPC     (incPC),
        .loadPC    (loadPC),
        .loadFlags (loadFlags),
        .alu_carry (alu_carry),
        .alu_zero  (alu_zero),
`ifdef NIB_HALT_EN
        .halt      (halt),
`endif
        .pc        (pc),
        .phase     (phase),
        .instr     (instr),
        .operand   (operand),
        .C         (C),
        .Z         (Z),
        .retired   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic inc, input logic ld, input logic lf,
                        input logic ac, input logic az);
        incPC     = inc;
        loadPC    = ld;
        loadFlags = lf;
        alu_carry = ac;
        alu_zero  = az;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rom[0]     = 8'h45;
        rom[1]     = 8'h73;
        rom[2]     = 8'h01;
        rom[3]     = 8'h23;
        rom[4]     = 8'hAF;
        rom[5]     = 8'hFF;
        rom[12'hFFF] = 8'h5C;
        reset_n = 1'b0;
        incPC = 0; loadPC = 0; loadFlags = 0;
        alu_carry = 0; alu_zero = 0; halt = 0;

        #12;
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_phase", 32'(phase), 32'h0);
        chk("rst_instr", 32'(instr), 32'h0);
        chk("rst_op", 32'(operand), 32'h0);
        chk("rst_C", 32'(C), 32'h0);
        chk("rst_Z", 32'(Z), 32'h0);
        chk("rst_ret", 32'(retired), 32'h0);
        reset_n = 1'b1;

        step(1, 0, 0, 0, 0);
        chk("s1_instr", 32'(instr), 32'h4);
        chk("s1_op", 32'(operand), 32'h5);
        chk("s1_pc", 32'(pc), 32'h1);
        chk("s1_phase", 32'(phase), 32'h1);
        step(0, 0, 1, 1, 0);
        chk("s2_pc", 32'(pc), 32'h1);
        chk("s2_ret", 32'(retired), 32'h1);
        chk("s2_phase", 32'(phase), 32'h0);
        chk("s2_C", 32'(C), 32'h1);
        chk("s2_Z", 32'(Z), 32'h0);
        step(1, 0, 0, 0, 0);
        chk("s3_instr", 32'(instr), 32'h7);
        chk("s3_op", 32'(operand), 32'h3);
        chk("s3_pc", 32'(pc), 32'h2);
        step(0, 0, 0, 0, 1);
        chk("s4_hold_C", 32'(C), 32'h1);
        chk("s4_hold_Z", 32'(Z), 32'h0);
        chk("s4_pc", 32'(pc), 32'h2);
        chk("s4_ret", 32'(retired), 32'h2);
        step(1, 0, 0, 0, 0);
        chk("jc_instr", 32'(instr), 32'h0);
        chk("jc_op", 32'(operand), 32'h1);
        chk("jc_pc", 32'(pc), 32'h3);
        step(1, 1, 0, 0, 0);
        chk("jc_taken_pc", 32'(pc), 32'h123);
        chk("jc_taken_ret", 32'(retired), 32'h3);
        step(1, 0, 0, 0, 0);
        chk("after_jmp_pc", 32'(pc), 32'h124);
        chk("after_jmp_phase", 32'(phase), 32'h1);

        #2 reset_n = 1'b0;
        #1;
        chk("arst_pc", 32'(pc), 32'h0);
        chk("arst_phase", 32'(phase), 32'h0);
        chk("arst_C", 32'(C), 32'h0);
        chk("arst_Z", 32'(Z), 32'h0);
        chk("arst_ret", 32'(retired), 32'h0);
        chk("arst_instr", 32'(instr), 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("njc_fetch_pc", 32'(pc), 32'h3);
        step(1, 0, 0, 0, 0);
        chk("njc_pc", 32'(pc), 32'h4);
        chk("njc_ret", 32'(retired), 32'h3);
        step(1, 0, 0, 0, 0);
        chk("njc_next_instr", 32'(instr), 32'hA);
        chk("njc_next_op", 32'(operand), 32'hF);
        chk("njc_next_pc", 32'(pc), 32'h5);
        step(0, 1, 0, 0, 0);
        chk("jmp_fff_pc", 32'(pc), 32'hFFF);
        chk("jmp_fff_ret", 32'(retired), 32'h4);
        step(1, 1, 1, 0, 1);
        chk("wrap_instr", 32'(instr), 32'h5);
        chk("wrap_op", 32'(operand), 32'hC);
        chk("wrap_pc", 32'(pc), 32'h0);
        chk("ph0_flags_C", 32'(C), 32'h0);
        chk("ph0_flags_Z", 32'(Z), 32'h1);
        step(0, 0, 0, 1, 0);
        chk("e_phase", 32'(phase), 32'h0);
        chk("e_ret", 32'(retired), 32'h5);
        chk("e_hold_C", 32'(C), 32'h0);
        chk("e_hold_Z", 32'(Z), 32'h1);

`ifdef NIB_HALT_EN
        step(1, 0, 0, 0, 0);
        chk("h_fetch_pc", 32'(pc), 32'h1);
        halt = 1'b1;
        step(0, 0, 0, 0, 0);
        chk("h_exec_pc", 32'(pc), 32'h1);
        chk("h_exec_ret", 32'(retired), 32'h6);
        chk("h_exec_phase", 32'(phase), 32'h0);
        for (int k = 0; k < 5; k++) begin
            step(1, 1, 1, 1, 0);
            chk("h_frz_pc", 32'(pc), 32'h1);
            chk("h_frz_phase", 32'(phase), 32'h0);
            chk("h_frz_ret", 32'(retired), 32'h6);
            chk("h_frz_instr", 32'(instr), 32'h4);
            chk("h_frz_C", 32'(C), 32'h0);
            chk("h_frz_Z", 32'(Z), 32'h1);
        end
        halt = 1'b0;
        step(1, 0, 0, 0, 0);
        chk("h_rel_pc", 32'(pc), 32'h1);
        chk("h_rel_phase", 32'(phase), 32'h0);
        step(1, 0, 0, 0, 0);
        chk("h_res_instr", 32'(instr), 32'h7);
        chk("h_res_pc", 32'(pc), 32'h2);
        chk("h_res_phase", 32'(phase), 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
